// File: rtl/xgmii_tx_arbiter.sv
// Frame-level round-robin arbiter sharing one XGMII TX lane.
// Grants whole frames, enforces IFG, aborts on link loss/underrun/oversize.
module xgmii_tx_arbiter #(
    parameter int NPORT     = 4,
    parameter int IFG_WORDS = 2,
    parameter int MAX_WORDS = 1200,
    parameter int START_TMO = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 link_up,
    input  logic [NPORT-1:0]     req,
    output logic [NPORT-1:0]     grant,
    input  logic [NPORT-1:0]     in_valid,
    input  logic [NPORT-1:0]     in_last,
    input  logic [64*NPORT-1:0]  in_txd,
    input  logic [8*NPORT-1:0]   in_txc,
    output logic [63:0]          xgmii_txd,
    output logic [7:0]           xgmii_txc,
    output logic                 busy,
    output logic [15:0]          abort_cnt
);

    localparam int PW  = $clog2(NPORT);
    localparam int WCW = $clog2(MAX_WORDS + 1);
    localparam int TW  = $clog2(START_TMO + 1);
    localparam int GW  = $clog2(IFG_WORDS + 1);

    localparam logic [63:0]    IDLE_D   = 64'h0707070707070707;
    localparam logic [63:0]    ERR_D    = 64'hFEFEFEFEFEFEFEFE;
    localparam logic [WCW-1:0] MAX_W    = WCW'(MAX_WORDS);
    localparam logic [TW-1:0]  TMO_LAST = TW'(START_TMO - 1);
    localparam logic [GW-1:0]  IFG_LAST = GW'(IFG_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_XFER,
        S_IFG
    } state_t;

    state_t         state;
    logic [PW-1:0]  rr;
    logic [WCW-1:0] word_cnt;
    logic [TW-1:0]  tmo;
    logic [GW-1:0]  ifg_cnt;

    logic [PW-1:0]  nxt_port;
    logic [PW-1:0]  idx;
    logic           nxt_found;

    logic           sel_valid;
    logic           sel_last;
    logic [63:0]    sel_txd;
    logic [7:0]     sel_txc;
    logic           overrun;

    // rr pointer always names the granted port, so it doubles as the mux select
    assign sel_valid = in_valid[rr];
    assign sel_last  = in_last[rr];
    assign sel_txd   = in_txd[rr*64 +: 64];
    assign sel_txc   = in_txc[rr*8 +: 8];
    assign overrun   = (word_cnt == MAX_W) && !sel_last;

    // first requester after the rr pointer, wrapping; scanned far-to-near so nearest wins
    always_comb begin
        nxt_port  = rr;
        nxt_found = 1'b0;
        idx       = '0;
        for (int k = NPORT; k >= 1; k--) begin
            idx = PW'((int'(rr) + k) % NPORT);
            if (req[idx]) begin
                nxt_port  = idx;
                nxt_found = 1'b1;
            end
        end
    end

    // arbitration FSM; every output is registered and defaults to an idle word
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= S_IDLE;
            grant     <= '0;
            rr        <= PW'(NPORT - 1);
            word_cnt  <= '0;
            tmo       <= '0;
            ifg_cnt   <= '0;
            busy      <= 1'b0;
            abort_cnt <= '0;
            xgmii_txd <= IDLE_D;
            xgmii_txc <= 8'hFF;
        end else begin
            xgmii_txd <= IDLE_D;
            xgmii_txc <= 8'hFF;
            unique case (state)
                S_IDLE: begin
                    if (link_up && nxt_found) begin
                        grant <= NPORT'(1) << nxt_port;
                        rr    <= nxt_port;
                        tmo   <= '0;
                        busy  <= 1'b1;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (sel_valid) begin
                        xgmii_txd <= sel_txd;
                        xgmii_txc <= sel_txc;
                        word_cnt  <= WCW'(1);
                        if (sel_last) begin
                            grant   <= '0;
                            busy    <= 1'b0;
                            ifg_cnt <= '0;
                            state   <= S_IFG;
                        end else begin
                            state <= S_XFER;
                        end
                    end else if (tmo == TMO_LAST) begin
                        grant   <= '0;
                        busy    <= 1'b0;
                        ifg_cnt <= '0;
                        state   <= S_IFG;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end
                S_XFER: begin
                    if (!link_up || !sel_valid || overrun) begin
                        if (link_up) begin
                            xgmii_txd <= ERR_D;
                        end
                        if (abort_cnt != 16'hFFFF) begin
                            abort_cnt <= abort_cnt + 16'd1;
                        end
                        grant   <= '0;
                        busy    <= 1'b0;
                        ifg_cnt <= '0;
                        state   <= S_IFG;
                    end else begin
                        xgmii_txd <= sel_txd;
                        xgmii_txc <= sel_txc;
                        word_cnt  <= word_cnt + WCW'(1);
                        if (sel_last) begin
                            grant   <= '0;
                            busy    <= 1'b0;
                            ifg_cnt <= '0;
                            state   <= S_IFG;
                        end
                    end
                end
                S_IFG: begin
                    if (ifg_cnt == IFG_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        ifg_cnt <= ifg_cnt + GW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
